// File: rtl/rr_stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package rr_stream_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits (N_REQ=1 still needs a 1-bit id).
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, searching upward
// modulo N_REQ. Purely combinational, shared with other arbiters.
module rr_pick
    import rr_stream_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic             any_o,
    output logic [IDW-1:0]   idx_o
);

    // Rotating priority scan; the first hit wins and masks later ones.
    always_comb begin
        int j;
        j        = 0;
        gnt_oh_o = '0;
        any_o    = 1'b0;
        idx_o    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!any_o && req_i[j]) begin
                any_o       = 1'b1;
                idx_o       = IDW'(j);
                gnt_oh_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_arb.sv
// Round-robin arbiter merging N_REQ valid/ready sources onto one registered
// output stream. Each grant lasts up to MAX_BURST beats or until the granted
// source drops valid; re-arbitration costs one IDLE bubble.
// Optional: define RR_STREAM_ARB_CNT_EN to add a 32-bit output beat counter.
module rr_stream_arb
    import rr_stream_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 8,
    localparam int IDW      = clog2_min1(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    input  logic [N_REQ-1:0]       in_vld,
    output logic [N_REQ-1:0]       in_rdy,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDW-1:0]         out_id,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   busy
`ifdef RR_STREAM_ARB_CNT_EN
    ,
    output logic [31:0]            beat_cnt
`endif
);

    localparam int BCW = clog2_min1(MAX_BURST);

    arb_state_t              state_q, state_d;
    logic [IDW-1:0]          ptr_q, ptr_d;
    logic [IDW-1:0]          gnt_q, gnt_d;
    logic [N_REQ-1:0]        gnt_oh_q, gnt_oh_d;
    logic [BCW-1:0]          burst_q, burst_d;

    logic [WIDTH-1:0]        out_data_q;
    logic [IDW-1:0]          out_id_q;
    logic                    out_vld_q;

    logic [N_REQ-1:0][WIDTH-1:0] req_data;
    logic [N_REQ-1:0]        pick_oh;
    logic                    pick_any;
    logic [IDW-1:0]          pick_idx;

    logic                    load_en;
    logic                    gnt_vld;
    logic                    xfer;
    logic                    last_beat;
    logic                    rel;

    assign req_data = in_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i    (in_vld),
        .ptr_i    (ptr_q),
        .gnt_oh_o (pick_oh),
        .any_o    (pick_any),
        .idx_o    (pick_idx)
    );

    // Handshake qualifiers: the output register can take a beat when empty or draining.
    always_comb begin
        load_en   = !out_vld_q || out_rdy;
        gnt_vld   = |(in_vld & gnt_oh_q);
        xfer      = (state_q == GRANT) && gnt_vld && load_en;
        last_beat = (burst_q == BCW'(MAX_BURST - 1));
        rel       = (state_q == GRANT) && (!gnt_vld || (xfer && last_beat));
    end

    // Next-state / grant logic; in_rdy only ever points at the granted source.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        gnt_oh_d = gnt_oh_q;
        burst_d  = burst_q;
        in_rdy   = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = GRANT;
                    gnt_d    = pick_idx;
                    gnt_oh_d = pick_oh;
                    burst_d  = '0;
                end
            end
            GRANT: begin
                in_rdy = gnt_oh_q & {N_REQ{load_en}};
                if (xfer) burst_d = burst_q + 1'b1;
                if (rel) begin
                    state_d = IDLE;
                    ptr_d   = (gnt_q == IDW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_oh_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_oh_q <= gnt_oh_d;
            burst_q  <= burst_d;
        end
    end

    // Output beat register: load on transfer, clear valid once drained, hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_id_q   <= '0;
        end else if (xfer) begin
            out_vld_q  <= 1'b1;
            out_data_q <= req_data[gnt_q];
            out_id_q   <= gnt_q;
        end else if (out_vld_q && out_rdy) begin
            out_vld_q  <= 1'b0;
        end
    end

`ifdef RR_STREAM_ARB_CNT_EN
    logic [31:0] beat_cnt_q;

    // Free-running count of beats delivered downstream, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (rst)                      beat_cnt_q <= '0;
        else if (out_vld_q && out_rdy) beat_cnt_q <= beat_cnt_q + 32'd1;
    end

    assign beat_cnt = beat_cnt_q;
`endif

    assign out_data = out_data_q;
    assign out_id   = out_id_q;
    assign out_vld  = out_vld_q;
    assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_rr_stream_arb.sv
// Self-checking bench for rr_stream_arb: incrementing-counter sources feed
// the arbiter; delivered beats are compared against the expected round-robin
// burst order derived from the arbitration rules.
module tb_rr_stream_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 8;

    logic               clk;
    logic               rst;
    logic [N*W-1:0]     in_data;
    logic [N-1:0]       in_vld;
    logic [N-1:0]       in_rdy;
    logic [W-1:0]       out_data;
    logic [1:0]         out_id;
    logic               out_vld;
    logic               out_rdy;
    logic               busy;
`ifdef RR_STREAM_ARB_CNT_EN
    logic [31:0]        beat_cnt;
`endif

    logic [N-1:0][W-1:0] src_data;
    assign in_data = src_data;

    rr_stream_arb #(.WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_id   (out_id),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .busy     (busy)
`ifdef RR_STREAM_ARB_CNT_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          seq [N];
    logic [W-1:0] obs_d [$];
    int          obs_id [$];
    int          obs_c [$];
    int          acc_n;
    int          cyc;
    logic [N-1:0] last_in_rdy;
    logic        last_out_vld, last_out_rdy;
    logic [W-1:0] last_out_data;
    logic [1:0]  last_out_id;

    // Source i emits i<<24 | running count.
    function automatic logic [W-1:0] exp_data(input int id, input int n);
        return (32'(id) << 24) | 32'(n);
    endfunction

    // With every source always valid, beat k belongs to burst k/MB and grants rotate 0..N-1.
    function automatic int rot_id(input int k);
        return (k / MB) % N;
    endfunction

    function automatic int rot_n(input int k);
        return ((k / MB) / N) * MB + (k % MB);
    endfunction

    task automatic drive_src();
        for (int i = 0; i < N; i++) src_data[i] = exp_data(i, seq[i]);
    endtask

    // One clock: snapshot pre-edge handshakes, record delivered beats, advance sources.
    task automatic tick();
        logic [N-1:0] hs;
        #4;
        hs            = in_vld & in_rdy;
        last_in_rdy   = in_rdy;
        last_out_vld  = out_vld;
        last_out_rdy  = out_rdy;
        last_out_data = out_data;
        last_out_id   = out_id;
        acc_n += $countones(hs);
        if (out_vld && out_rdy) begin
            obs_d.push_back(out_data);
            obs_id.push_back(int'(out_id));
            obs_c.push_back(cyc);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) seq[i]++;
        drive_src();
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_vld = '0; out_rdy = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        drive_src();
        obs_d.delete(); obs_id.delete(); obs_c.delete();
        acc_n = 0; cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = '0; out_rdy = 1'b1;
        for (int i = 0; i < N; i++) seq[i] = 0;
        drive_src();
        tick(); tick();
        n_checks++; if (out_vld !== 1'b0)   begin n_fail++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
        n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++; if (out_id !== '0)      begin n_fail++; $display("FAIL reset_out_id: got %0d want 0", out_id); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (in_rdy !== '0)      begin n_fail++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
`ifdef RR_STREAM_ARB_CNT_EN
        n_checks++; if (beat_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
`endif
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            n_checks++;
            if (out_vld !== 1'b0 || busy !== 1'b0 || in_rdy !== '0) begin
                n_fail++;
                $display("FAIL idle_quiet[%0d]: got vld=%b busy=%b rdy=%b want 0/0/0", n, out_vld, busy, in_rdy);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        in_vld = 4'b0001;
        for (int n = 0; n < 100 && obs_d.size() < 16; n++) tick();
        n_checks++;
        if (obs_d.size() < 16) begin
            n_fail++; $display("FAIL single_timeout: got %0d beats want 16", obs_d.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                n_checks++;
                if (obs_id[k] != 0 || obs_d[k] !== exp_data(0, k)) begin
                    n_fail++; $display("FAIL single_beat[%0d]: got id%0d %h want id0 %h", k, obs_id[k], obs_d[k], exp_data(0, k));
                end
                if (k > 0) begin
                    n_checks++;
                    if (obs_c[k] - obs_c[k-1] != ((k % MB == 0) ? 2 : 1)) begin
                        n_fail++; $display("FAIL single_gap[%0d]: got %0d want %0d", k, obs_c[k] - obs_c[k-1], (k % MB == 0) ? 2 : 1);
                    end
                end
            end
            n_checks++;
            if (obs_c[0] != 2) begin n_fail++; $display("FAIL single_latency: got cycle %0d want 2", obs_c[0]); end
        end
    endtask

    task automatic test_rotate();
        do_reset();
        in_vld = 4'b1111;
        for (int n = 0; n < 200 && obs_d.size() < 40; n++) tick();
        n_checks++;
        if (obs_d.size() < 40) begin
            n_fail++; $display("FAIL rotate_timeout: got %0d beats want 40", obs_d.size());
        end else begin
            for (int k = 0; k < 40; k++) begin
                n_checks++;
                if (obs_id[k] != rot_id(k) || obs_d[k] !== exp_data(rot_id(k), rot_n(k))) begin
                    n_fail++; $display("FAIL rotate_beat[%0d]: got id%0d %h want id%0d %h", k, obs_id[k], obs_d[k], rot_id(k), exp_data(rot_id(k), rot_n(k)));
                end
                if (k > 0) begin
                    n_checks++;
                    if (obs_c[k] - obs_c[k-1] != ((k % MB == 0) ? 2 : 1)) begin
                        n_fail++; $display("FAIL rotate_gap[%0d]: got %0d want %0d", k, obs_c[k] - obs_c[k-1], (k % MB == 0) ? 2 : 1);
                    end
                end
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        in_vld = 4'b1100;
        for (int n = 0; n < 100 && obs_d.size() < 11; n++) begin
            if (seq[2] >= 3) in_vld[2] = 1'b0;
            tick();
        end
        n_checks++;
        if (obs_d.size() < 11) begin
            n_fail++; $display("FAIL drop_timeout: got %0d beats want 11", obs_d.size());
        end else begin
            for (int k = 0; k < 11; k++) begin
                automatic int eid = (k < 3) ? 2 : 3;
                automatic int en  = (k < 3) ? k : k - 3;
                n_checks++;
                if (obs_id[k] != eid || obs_d[k] !== exp_data(eid, en)) begin
                    n_fail++; $display("FAIL drop_beat[%0d]: got id%0d %h want id%0d %h", k, obs_id[k], obs_d[k], eid, exp_data(eid, en));
                end
            end
            n_checks++;
            if (obs_c[3] - obs_c[2] != 3) begin
                n_fail++; $display("FAIL drop_gap: got %0d want 3", obs_c[3] - obs_c[2]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        in_vld = 4'b1111;
        for (int n = 0; n < 400; n++) begin
            out_rdy = 1'($urandom_range(0, 1));
            tick();
            n_checks++;
            if ($countones(last_in_rdy) > 1) begin
                n_fail++; $display("FAIL stall_onehot[%0d]: got in_rdy=%b want at most one bit", n, last_in_rdy);
            end
            if (last_out_vld && !last_out_rdy) begin
                n_checks++;
                if (out_vld !== 1'b1 || out_data !== last_out_data || out_id !== last_out_id) begin
                    n_fail++; $display("FAIL stall_hold[%0d]: got vld=%b %h id%0d want 1 %h id%0d", n, out_vld, out_data, out_id, last_out_data, last_out_id);
                end
            end
        end
        in_vld = '0; out_rdy = 1'b1;
        for (int n = 0; n < 4; n++) tick();
        n_checks++;
        if (obs_d.size() != acc_n) begin
            n_fail++; $display("FAIL stall_count: got %0d delivered want %0d accepted", obs_d.size(), acc_n);
        end
        for (int k = 0; k < obs_d.size(); k++) begin
            n_checks++;
            if (obs_id[k] != rot_id(k) || obs_d[k] !== exp_data(rot_id(k), rot_n(k))) begin
                n_fail++; $display("FAIL stall_beat[%0d]: got id%0d %h want id%0d %h", k, obs_id[k], obs_d[k], rot_id(k), exp_data(rot_id(k), rot_n(k)));
            end
        end
`ifdef RR_STREAM_ARB_CNT_EN
        n_checks++;
        if (beat_cnt !== 32'(obs_d.size())) begin
            n_fail++; $display("FAIL stall_beat_cnt: got %0d want %0d", beat_cnt, obs_d.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        int snap;
        do_reset();
        in_vld = 4'b1111;
        for (int n = 0; n < 12; n++) tick();
        out_rdy = 1'b0;
        tick();
        n_checks++;
        if (out_vld !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got vld=%b busy=%b want 1/1", out_vld, busy);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (out_vld !== 1'b0 || busy !== 1'b0 || in_rdy !== '0 || out_id !== '0) begin
            n_fail++; $display("FAIL midrst_post: got vld=%b busy=%b rdy=%b id=%0d want 0/0/0/0", out_vld, busy, in_rdy, out_id);
        end
`ifdef RR_STREAM_ARB_CNT_EN
        n_checks++;
        if (beat_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_beat_cnt: got %0d want 0", beat_cnt); end
`endif
        rst = 1'b0; out_rdy = 1'b1;
        obs_d.delete(); obs_id.delete(); obs_c.delete();
        cyc = 0;
        snap = seq[0];
        for (int n = 0; n < 20 && obs_d.size() < 1; n++) tick();
        n_checks++;
        if (obs_d.size() < 1) begin
            n_fail++; $display("FAIL midrst_timeout: got 0 beats want 1");
        end else if (obs_id[0] != 0 || obs_d[0] !== exp_data(0, snap) || obs_c[0] != 2) begin
            n_fail++; $display("FAIL midrst_restart: got id%0d %h cyc%0d want id0 %h cyc2", obs_id[0], obs_d[0], obs_c[0], exp_data(0, snap));
        end
    endtask

    initial begin
        cyc = 0; acc_n = 0;
        test_reset();
        test_single();
        test_rotate();
        test_drop();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rr_stream_arb.md
Name: rr_stream_arb

Overview:
- Round-robin arbiter sharing one valid/ready output stream between N_REQ stream sources, such as incrementing-counter data sources.
- Grants one requester at a time for a burst of up to MAX_BURST beats, then rotates.
- Output is registered and follows the same valid/ready handshake, so it drops straight into the bubble/stream test fabric between sources and a sink.

Parameters:
- WIDTH, 32, data width per beat.
- N_REQ, 4, number of requesters (>=1).
- MAX_BURST, 8, max beats per grant before forced rotation (>=1).
- IDW, derived localparam = max(1, $clog2(N_REQ)), requester index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  N_REQ*WIDTH  requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- in_vld  in  N_REQ  per-requester valid.
- in_rdy  out  N_REQ  per-requester ready; at most one bit set.
- out_data  out  WIDTH  registered output beat.
- out_id  out  IDW  index of the requester that produced out_data.
- out_vld  out  1  output valid.
- out_rdy  in  1  downstream ready.
- busy  out  1  high while in GRANT state.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - out_vld=0, out_data=0, out_id=0, busy=0, in_rdy=0.
  - state=IDLE, ptr=0, gnt=0, burst_cnt=0.
- Reset mid-operation discards any pending output beat and the current grant.
- FSM states: IDLE, GRANT.
- IDLE:
  - in_rdy=0.
  - If any in_vld is set, gnt is the first set in_vld at or after ptr, searching upward modulo N_REQ.
  - Next state GRANT, burst_cnt cleared. Otherwise stay in IDLE.
  - Arbitration costs exactly one bubble cycle; no transfer occurs in IDLE.
- GRANT:
  - load_en = !out_vld || out_rdy.
  - in_rdy[gnt] = load_en; all other in_rdy bits = 0. in_rdy may depend combinationally on out_rdy.
  - Transfer when in_vld[gnt] && in_rdy[gnt]: out_data <= in_data[gnt], out_id <= gnt, out_vld <= 1, burst_cnt++.
  - Release, on the clock edge ending the cycle, to IDLE with ptr <= (gnt+1) mod N_REQ, when either:
    - a transfer occurs with burst_cnt == MAX_BURST-1, or
    - in_vld[gnt] == 0 (requester dropped valid mid-burst; no transfer that cycle).
  - No release while in_vld[gnt]=1 but stalled by out_rdy=0; the grant is held and burst_cnt is frozen.
- Output register:
  - If out_vld && out_rdy and no new load: out_vld <= 0.
  - While out_vld && !out_rdy: out_data and out_id are held stable.
- Latency: input handshake to out_vld is 1 cycle. Full throughput within a burst (one beat per cycle when out_rdy=1).
- Boundary conditions:
  - Single active requester: bursts of MAX_BURST beats separated by one IDLE bubble; throughput MAX_BURST/(MAX_BURST+1).
  - MAX_BURST=1: release after every beat.
  - N_REQ=1: ptr always 0.
  - ptr wraps from N_REQ-1 to 0.
  - Requesters not granted must hold their data; the arbiter never drops an accepted beat.
- busy = (state == GRANT).

Optional Feature:
- Macro: RR_STREAM_ARB_CNT_EN.
- Defined: adds output port beat_cnt [31:0].
  - Increments on each out_vld && out_rdy and wraps at 2^32.
  - Cleared by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package rr_stream_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - function clog2_min1 used for IDW.
- One sub-module, rr_pick: combinational, N_REQ-wide request vector plus ptr in, one-hot/any-valid plus index out.
- Reused by other arbiters in the codebase.

Test Plan:
- Reset, then all in_vld=0 -> out_vld=0, in_rdy=0, busy=0, state stays IDLE.
- N_REQ=4, MAX_BURST=8, only req0 valid streaming 0,1,2..., out_rdy=1:
  - out_data 0..7 with out_id=0.
  - One bubble cycle, then 8..15.
- All four requesters valid, out_rdy=1:
  - Grants rotate 0,1,2,3,0, each burst exactly 8 beats, one bubble between bursts.
  - out_id matches the source of every beat.
- Requester 2 drops in_vld after 3 beats while req3 is valid:
  - Burst ends after 3 beats.
  - Next grant goes to req3 (ptr=3).
- out_rdy toggled randomly 50% during a burst:
  - No lost or duplicated beats; out_data stable while out_vld && !out_rdy.
  - burst_cnt counts only accepted beats.
- rst asserted mid-burst with out_vld=1:
  - Next cycle out_vld=0 and ptr=0.
  - Arbitration restarts from req0.
  - With RR_STREAM_ARB_CNT_EN, beat_cnt reads 0.
